ula_sequencer: RTL and testbench

//  Instruction-driven controller that sits in front of the combinational ula (4-bit ALU, 3-bit select).
//  - Holds a small register file.
//  - Accepts ALU instructions over a valid/ready handshake and drives ula operands/select from registers.
//  - Samples the ula result after a fixed settle time and writes it back, with a done pulse.

---
 rtl/ula_sequencer.sv | 121 ++++++++++++
 tb/tb_ula_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencer.sv
// rtl/ula_sequencer.sv - clocked register-file front end that issues instructions to an external combinational ula
module ula_sequencer #(
  parameter int DATA_W      = 4,
  parameter int NREGS       = 4,
  parameter int EXEC_CYCLES = 1,
  localparam int AW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_ra,
  input  logic [AW-1:0]     instr_rb,
  output logic [DATA_W-1:0] ula_opA,
  output logic [DATA_W-1:0] ula_opB,
  output logic [2:0]        ula_select,
  input  logic [DATA_W-1:0] ula_saida,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [7:0]        op_count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Counter only needs to reach EXEC_CYCLES-1; keep at least one bit.
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(EXEC_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_finish;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [AW-1:0]       r_rd;
  logic [CW-1:0]       r_cnt;

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and sequencing strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    instr_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == LAST_CNT) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, settle counter, loads, write-back and status.
  // Operands are read with pre-edge register values, so a same-cycle load
  // never leaks into the instruction being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      ula_opA    <= '0;
      ula_opB    <= '0;
      ula_select <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      done       <= 1'b0;
      result     <= '0;
      op_count   <= '0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        ula_opA    <= r_regs[instr_ra];
        ula_opB    <= r_regs[instr_rb];
        ula_select <= instr_op;
        r_rd       <= instr_rd;
        r_cnt      <= '0;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_IDLE) && ld_en) begin
        r_regs[ld_addr] <= ld_data;
      end
      if (w_finish) begin
        r_regs[r_rd] <= ula_saida;
        result       <= ula_saida;
        done         <= 1'b1;
        op_count     <= op_count + 8'd1;
      end
    end
  end

  assign rd_data = r_regs[rd_addr];

endmodule

// File: tb/tb_ula_sequencer.sv
// tb/tb_ula_sequencer.sv - randomized scoreboard bench for ula_sequencer with a stub ula
module tb_ula_sequencer;

  localparam int EC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic [3:0] ula_opA, ula_opB;
  logic [2:0] ula_select;
  logic [3:0] ula_saida;
  logic       done;
  logic [3:0] result;
  logic [7:0] op_count;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  always #5 clk = ~clk;

  ula_sequencer #(.DATA_W(4), .NREGS(4), .EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .ula_opA(ula_opA), .ula_opB(ula_opB), .ula_select(ula_select),
    .ula_saida(ula_saida),
    .done(done), .result(result), .op_count(op_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Stub ula: an arbitrary 4-bit function, or a scripted value.
  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ~a;
      3'd6: alu = a + 4'd1;
      default: alu = b;
    endcase
  endfunction

  logic       use_stub = 1'b0;
  logic [3:0] stub_val = 4'd0;
  logic [3:0] stub_exp = 4'd0;
  assign ula_saida = use_stub ? stub_val : alu(ula_opA, ula_opB, ula_select);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] res;
    logic [7:0] cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference model state.
  logic [3:0] mreg [4];
  int         mbusy;
  logic       pend;
  logic [1:0] prd;
  logic [3:0] pval;
  logic [3:0] m_a, m_b, mres;
  logic [2:0] m_sel;
  logic [7:0] mcount;
  int         cyc;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mreg[i] = 4'd0;
    mbusy = 0; pend = 1'b0; prd = 2'd0; pval = 4'd0;
    m_a = 4'd0; m_b = 4'd0; m_sel = 3'd0; mres = 4'd0; mcount = 8'd0;
    sbq.delete();
  endtask

  // Monitor: every done pulse must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_op_count", op_count, e.cnt);
      end
    end
  end

  // One clock of stimulus; called in the low phase, returns at the next negedge.
  task automatic do_cycle(input logic ld, input logic [1:0] la, input logic [3:0] ldd,
                          input logic iv, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb, output logic acc);
    logic mdone;
    logic idle;
    mdone = 1'b0;
    if (mbusy > 0) begin
      mbusy--;
      if (mbusy == 0 && pend) begin
        mreg[prd] = pval;
        mres      = pval;
        mcount    = mcount + 8'd1;
        pend      = 1'b0;
        mdone     = 1'b1;
      end
    end
    chk("instr_ready", instr_ready, mbusy == 0);
    chk("done", done, mdone);
    chk("ula_opA", ula_opA, m_a);
    chk("ula_opB", ula_opB, m_b);
    chk("ula_select", ula_select, m_sel);
    chk("result", result, mres);
    chk("op_count", op_count, mcount);
    chk("rd_data", rd_data, mreg[rd_addr]);

    idle        = (mbusy == 0);
    ld_en       = ld;
    ld_addr     = la;
    ld_data     = ldd;
    instr_valid = iv;
    instr_op    = op;
    instr_rd    = rd;
    instr_ra    = ra;
    instr_rb    = rb;
    rd_addr     = 2'($urandom_range(0, 3));
    acc         = iv && idle;
    if (acc) begin
      exp_t e;
      m_a   = mreg[ra];
      m_b   = mreg[rb];
      m_sel = op;
      pval  = use_stub ? stub_exp : alu(m_a, m_b, op);
      prd   = rd;
      pend  = 1'b1;
      mbusy = EC + 1;
      e.res = pval;
      e.cnt = mcount + 8'd1;
      sbq.push_back(e);
    end
    if (ld && idle) mreg[la] = ldd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    logic a;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 2'd0, 4'd0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, a);
  endtask

  task automatic load(input logic [1:0] la, input logic [3:0] d);
    logic a;
    do_cycle(1'b1, la, d, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, a);
  endtask

  // Holds instr_valid high until the instruction is taken.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, output int acc_cyc);
    logic a;
    a = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 20 && !a; i++) begin
      acc_cyc = cyc;
      do_cycle(1'b0, 2'd0, 4'd0, 1'b1, op, rd, ra, rb, a);
    end
    if (!a) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_opA", ula_opA, 4'd0);
    chk("rst_opB", ula_opB, 4'd0);
    chk("rst_sel", ula_select, 3'd0);
    chk("rst_result", result, 4'd0);
    chk("rst_op_count", op_count, 8'd0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk("rst_reg", rd_data, 4'd0);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3;
    logic a;
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; rd_addr = '0;
    cyc = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_n(2);

    // Reset in the middle of an operation: no done, everything cleared.
    load(2'd1, 4'd7);
    issue(3'd0, 2'd2, 2'd1, 2'd1, c1);
    idle_n(1);
    do_reset();
    idle_n(EC + 3);

    // Basic op with a scripted ula result.
    load(2'd0, 4'b1100);
    load(2'd1, 4'b0011);
    use_stub = 1'b1; stub_val = 4'b0101; stub_exp = 4'b0101;
    issue(3'd0, 2'd2, 2'd0, 2'd1, c1);
    idle_n(EC + 1);
    use_stub = 1'b0;
    rd_addr = 2'd2;
    #1;
    chk("t2_rd_r2", rd_data, 4'b0101);
    chk("t2_op_count", op_count, 8'd1);

    // ula result changes mid-EXEC; the value at the last edge is written.
    load(2'd0, 4'b1010);
    use_stub = 1'b1; stub_val = 4'b0001; stub_exp = 4'b0110;
    issue(3'd7, 2'd1, 2'd0, 2'd0, c1);
    idle_n(1);
    stub_val = 4'b0110;
    idle_n(EC + 1);
    use_stub = 1'b0;

    // Back-to-back issue with valid held high.
    issue(3'd0, 2'd3, 2'd0, 2'd1, c1);
    issue(3'd1, 2'd2, 2'd3, 2'd0, c2);
    issue(3'd4, 2'd1, 2'd2, 2'd3, c3);
    chk("b2b_gap1", 32'(c2 - c1), 32'(EC + 1));
    chk("b2b_gap2", 32'(c3 - c2), 32'(EC + 1));
    idle_n(EC + 2);

    // Load coinciding with accept, then a load during EXEC that is dropped.
    load(2'd0, 4'b1001);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, 3'd5, 2'd3, 2'd0, 2'd1, a);
    chk("t5_accepted", a, 1'b1);
    #1;
    chk("t5_opA_preload", ula_opA, 4'b1001);
    do_cycle(1'b1, 2'd1, 4'b0101, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, a);
    idle_n(EC + 2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a);
    end
    idle_n(EC + 2);

    // rd==ra chain, 256 ops: op_count wraps back to zero.
    do_reset();
    load(2'd0, 4'b0010);
    for (int i = 0; i < 256; i++) issue(3'd6, 2'd0, 2'd0, 2'd1, c1);
    idle_n(EC + 2);
    chk("chain_op_count_wrap", op_count, 8'd0);
    rd_addr = 2'd0;
    #1;
    chk("chain_r0", rd_data, 4'b0010);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
